tod_counter: RTL and testbench

Parametrised time-of-day counter with seconds, minutes and hours fields. It generalises a fixed sec/min/hour FSM chain with:
- a clock prescaler
- configurable field moduli and width
- a count enable and a 12/24-hour display mode
- range-checked parallel load
- a programmable alarm comparator with a one-cycle hit pulse

It sits between the system clock domain logic and display or alarm consumers.

---
 rtl/tod_counter_if.sv | 36 +++
 rtl/tod_counter.sv | 143 ++++++++++++++
 tb/tb_tod_counter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tod_counter_if.sv
// Bus bundle for tod_counter: control/load/alarm inputs and time/pulse outputs.
interface tod_counter_if #(
    parameter int unsigned W = 6
);
    logic         en;
    logic         load;
    logic [W-1:0] sec_in;
    logic [W-1:0] min_in;
    logic [W-1:0] hour_in;
    logic         alarm_set;
    logic [W-1:0] alarm_sec;
    logic [W-1:0] alarm_min;
    logic [W-1:0] alarm_hour;
    logic         alarm_en;
    logic         mode_12h;
    logic [W-1:0] sec_out;
    logic [W-1:0] min_out;
    logic [W-1:0] hour_out;
    logic         pm;
    logic         tick;
    logic         day_wrap;
    logic         alarm_hit;
    logic         load_err;

    modport master (
        output en, load, sec_in, min_in, hour_in,
        output alarm_set, alarm_sec, alarm_min, alarm_hour, alarm_en, mode_12h,
        input  sec_out, min_out, hour_out, pm, tick, day_wrap, alarm_hit, load_err
    );

    modport slave (
        input  en, load, sec_in, min_in, hour_in,
        input  alarm_set, alarm_sec, alarm_min, alarm_hour, alarm_en, mode_12h,
        output sec_out, min_out, hour_out, pm, tick, day_wrap, alarm_hit, load_err
    );
endinterface

// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled second tick, sec/min/hour carry chain,
// range-checked load, alarm comparator and 12h display decode.
module tod_counter #(
    parameter int unsigned W        = 6,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned SEC_MAX  = 59,
    parameter int unsigned MIN_MAX  = 59,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic            clk,
    input  logic            rst,
    tod_counter_if.slave    bus
);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [W-1:0]  SEC_LAST   = W'(SEC_MAX);
    localparam logic [W-1:0]  MIN_LAST   = W'(MIN_MAX);
    localparam logic [W-1:0]  HOUR_LAST  = W'(HOUR_MAX);
    localparam logic [W-1:0]  HOUR_NOON  = W'(12);
    localparam bit            DECODE_12H = (HOUR_MAX == 23);

    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [W-1:0]  alarm_sec_q, alarm_sec_d, alarm_min_q, alarm_min_d;
    logic [W-1:0]  alarm_hour_q, alarm_hour_d;
    logic          tick_q, tick_d, day_wrap_q, day_wrap_d;
    logic          alarm_hit_q, alarm_hit_d, load_err_q, load_err_d;

    logic          tick_ev_c, load_ok_c, sec_wrap_c, min_wrap_c, hour_wrap_c;
    logic [W-1:0]  sec_nxt_c, min_nxt_c, hour_nxt_c, hour_disp_c;

    // Carry chain: values the fields take on a tick event
    always_comb begin
        sec_wrap_c  = (sec_q == SEC_LAST);
        min_wrap_c  = (min_q == MIN_LAST);
        hour_wrap_c = (hour_q == HOUR_LAST);
        sec_nxt_c   = sec_wrap_c ? '0 : sec_q + W'(1);
        min_nxt_c   = min_q;
        hour_nxt_c  = hour_q;
        if (sec_wrap_c) begin
            min_nxt_c = min_wrap_c ? '0 : min_q + W'(1);
            if (min_wrap_c) begin
                hour_nxt_c = hour_wrap_c ? '0 : hour_q + W'(1);
            end
        end
    end

    always_comb begin
        tick_ev_c = bus.en && (presc_q == PRESC_LAST);
        load_ok_c = (bus.sec_in <= SEC_LAST) && (bus.min_in <= MIN_LAST) &&
                    (bus.hour_in <= HOUR_LAST);

        presc_d      = presc_q;
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        alarm_sec_d  = alarm_sec_q;
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        tick_d       = 1'b0;
        day_wrap_d   = 1'b0;
        alarm_hit_d  = 1'b0;
        load_err_d   = 1'b0;

        // Any load strobe swallows a coincident tick event; a rejected load holds everything
        if (bus.load) begin
            if (load_ok_c) begin
                sec_d   = bus.sec_in;
                min_d   = bus.min_in;
                hour_d  = bus.hour_in;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick_ev_c) begin
            presc_d     = '0;
            sec_d       = sec_nxt_c;
            min_d       = min_nxt_c;
            hour_d      = hour_nxt_c;
            tick_d      = 1'b1;
            day_wrap_d  = sec_wrap_c && min_wrap_c && hour_wrap_c;
            alarm_hit_d = bus.alarm_en && (sec_nxt_c == alarm_sec_q) &&
                          (min_nxt_c == alarm_min_q) && (hour_nxt_c == alarm_hour_q);
        end else if (bus.en) begin
            presc_d = presc_q + PW'(1);
        end

        if (bus.alarm_set) begin
            alarm_sec_d  = bus.alarm_sec;
            alarm_min_d  = bus.alarm_min;
            alarm_hour_d = bus.alarm_hour;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            hour_q       <= '0;
            alarm_sec_q  <= '0;
            alarm_min_q  <= '0;
            alarm_hour_q <= '0;
            tick_q       <= 1'b0;
            day_wrap_q   <= 1'b0;
            alarm_hit_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            alarm_sec_q  <= alarm_sec_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            tick_q       <= tick_d;
            day_wrap_q   <= day_wrap_d;
            alarm_hit_q  <= alarm_hit_d;
            load_err_q   <= load_err_d;
        end
    end

    // 12h display decode; only meaningful for a 0..23 hour field
    always_comb begin
        hour_disp_c = hour_q;
        if (DECODE_12H && bus.mode_12h) begin
            if (hour_q == '0) begin
                hour_disp_c = HOUR_NOON;
            end else if (hour_q > HOUR_NOON) begin
                hour_disp_c = hour_q - HOUR_NOON;
            end
        end
    end

    assign bus.sec_out   = sec_q;
    assign bus.min_out   = min_q;
    assign bus.hour_out  = hour_disp_c;
    assign bus.pm        = (hour_q >= HOUR_NOON);
    assign bus.tick      = tick_q;
    assign bus.day_wrap  = day_wrap_q;
    assign bus.alarm_hit = alarm_hit_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_tod_counter.sv
// Randomized bench for tod_counter: two instances (CLK_DIV 3 and 1) checked
// every cycle against a seconds-of-day reference model.
module tb_tod_counter;
    localparam int W        = 6;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int NDUT     = 2;
    localparam int SPM      = SEC_MAX + 1;
    localparam int SPH      = SPM * (MIN_MAX + 1);
    localparam int TOTAL    = SPH * (HOUR_MAX + 1);

    logic clk, rst;
    logic en, load, alarm_set, alarm_en, mode_12h;
    logic [W-1:0] sec_in, min_in, hour_in, alarm_sec, alarm_min, alarm_hour;

    tod_counter_if #(.W(W)) if0 ();
    tod_counter_if #(.W(W)) if1 ();

    assign if0.en = en;               assign if1.en = en;
    assign if0.load = load;           assign if1.load = load;
    assign if0.sec_in = sec_in;       assign if1.sec_in = sec_in;
    assign if0.min_in = min_in;       assign if1.min_in = min_in;
    assign if0.hour_in = hour_in;     assign if1.hour_in = hour_in;
    assign if0.alarm_set = alarm_set; assign if1.alarm_set = alarm_set;
    assign if0.alarm_sec = alarm_sec; assign if1.alarm_sec = alarm_sec;
    assign if0.alarm_min = alarm_min; assign if1.alarm_min = alarm_min;
    assign if0.alarm_hour = alarm_hour; assign if1.alarm_hour = alarm_hour;
    assign if0.alarm_en = alarm_en;   assign if1.alarm_en = alarm_en;
    assign if0.mode_12h = mode_12h;   assign if1.mode_12h = mode_12h;

    tod_counter #(.W(W), .CLK_DIV(3), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX), .HOUR_MAX(HOUR_MAX))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    tod_counter #(.W(W), .CLK_DIV(1), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX), .HOUR_MAX(HOUR_MAX))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: time as seconds since midnight, enabled cycles since the last second
    int m_t   [NDUT];
    int m_cnt [NDUT];
    int m_as, m_am, m_ah;
    bit m_tick [NDUT];
    bit m_wrap [NDUT];
    bit m_hit  [NDUT];
    bit m_err  [NDUT];

    function automatic int div_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int f_sec(input int t);  return t % SPM;               endfunction
    function automatic int f_min(input int t);  return (t / SPM) % (MIN_MAX + 1); endfunction
    function automatic int f_hour(input int t); return t / SPH;               endfunction

    function automatic int disp_hour(input int h, input bit m12);
        if (!m12)   return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_t[k] = 0; m_cnt[k] = 0;
            m_tick[k] = 0; m_wrap[k] = 0; m_hit[k] = 0; m_err[k] = 0;
        end
        m_as = 0; m_am = 0; m_ah = 0;
    endtask

    // Next state from the inputs presented for the coming rising edge
    task automatic model_step();
        bit ok;
        ok = (int'(sec_in) <= SEC_MAX) && (int'(min_in) <= MIN_MAX) && (int'(hour_in) <= HOUR_MAX);
        for (int k = 0; k < NDUT; k++) begin
            m_tick[k] = 0; m_wrap[k] = 0; m_hit[k] = 0; m_err[k] = 0;
            if (load) begin
                if (ok) begin
                    m_t[k]   = int'(hour_in) * SPH + int'(min_in) * SPM + int'(sec_in);
                    m_cnt[k] = 0;
                end else begin
                    m_err[k] = 1;
                end
            end else if (en) begin
                if (m_cnt[k] == div_of(k) - 1) begin
                    m_cnt[k]  = 0;
                    m_t[k]    = (m_t[k] + 1) % TOTAL;
                    m_tick[k] = 1;
                    m_wrap[k] = (m_t[k] == 0);
                    m_hit[k]  = alarm_en && f_sec(m_t[k]) == m_as &&
                                f_min(m_t[k]) == m_am && f_hour(m_t[k]) == m_ah;
                end else begin
                    m_cnt[k]++;
                end
            end
        end
        if (alarm_set) begin
            m_as = int'(alarm_sec); m_am = int'(alarm_min); m_ah = int'(alarm_hour);
        end
    endtask

    task automatic check_dut(input int k, input logic [W-1:0] s, input logic [W-1:0] mn,
                             input logic [W-1:0] h, input logic p, input logic tk,
                             input logic dw, input logic ah, input logic le);
        chk($sformatf("d%0d.sec", k),       32'(s),  32'(f_sec(m_t[k])));
        chk($sformatf("d%0d.min", k),       32'(mn), 32'(f_min(m_t[k])));
        chk($sformatf("d%0d.hour_out", k),  32'(h),  32'(disp_hour(f_hour(m_t[k]), mode_12h)));
        chk($sformatf("d%0d.pm", k),        32'(p),  32'(f_hour(m_t[k]) >= 12));
        chk($sformatf("d%0d.tick", k),      32'(tk), 32'(m_tick[k]));
        chk($sformatf("d%0d.day_wrap", k),  32'(dw), 32'(m_wrap[k]));
        chk($sformatf("d%0d.alarm_hit", k), 32'(ah), 32'(m_hit[k]));
        chk($sformatf("d%0d.load_err", k),  32'(le), 32'(m_err[k]));
    endtask

    task automatic check_all();
        check_dut(0, if0.sec_out, if0.min_out, if0.hour_out, if0.pm, if0.tick,
                  if0.day_wrap, if0.alarm_hit, if0.load_err);
        check_dut(1, if1.sec_out, if1.min_out, if1.hour_out, if1.pm, if1.tick,
                  if1.day_wrap, if1.alarm_hit, if1.load_err);
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge
    task automatic cyc();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    task automatic load_hms(input int h, input int m, input int s);
        load = 1'b1;
        hour_in = W'(h); min_in = W'(m); sec_in = W'(s);
        cyc();
        load = 1'b0;
    endtask

    task automatic set_alarm(input int h, input int m, input int s);
        alarm_set = 1'b1;
        alarm_hour = W'(h); alarm_min = W'(m); alarm_sec = W'(s);
        cyc();
        alarm_set = 1'b0;
    endtask

    int hrs [5] = '{0, 11, 12, 13, 23};

    initial begin
        rst = 1'b0;
        en = 0; load = 0; alarm_set = 0; alarm_en = 0; mode_12h = 0;
        sec_in = '0; min_in = '0; hour_in = '0;
        alarm_sec = '0; alarm_min = '0; alarm_hour = '0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        rst = 1'b1;

        // free run, then reset mid-count
        en = 1'b1;
        repeat (12) cyc();
        repeat (2) cyc();
        do_reset();

        // day wrap
        load_hms(23, 59, 58);
        repeat (8) cyc();

        // rejected load, then load coincident with a tick event
        load_hms(10, 60, 0);
        load_hms(24, 0, 0);
        load_hms(1, 1, 1);
        repeat (2) cyc();
        load_hms(5, 6, 7);
        repeat (6) cyc();

        // alarm hit, direct load into alarm time, alarm disabled
        set_alarm(0, 1, 0);
        alarm_en = 1'b1;
        load_hms(0, 0, 59);
        repeat (4) cyc();
        load_hms(0, 1, 0);
        repeat (2) cyc();
        alarm_en = 1'b0;
        load_hms(0, 0, 59);
        repeat (4) cyc();

        // 12h decode with time frozen
        en = 1'b0;
        mode_12h = 1'b1;
        foreach (hrs[i]) begin
            load_hms(hrs[i], 30, 0);
            cyc();
        end
        mode_12h = 1'b0;
        cyc();

        // enable gap mid-count
        en = 1'b1;
        load_hms(1, 2, 3);
        cyc();
        en = 1'b0;
        repeat (10) cyc();
        en = 1'b1;
        repeat (3) cyc();

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            en        = ($urandom_range(0, 9) != 0);
            load      = ($urandom_range(0, 19) == 0);
            alarm_set = ($urandom_range(0, 29) == 0);
            mode_12h  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 49) == 0) alarm_en = ~alarm_en;
            case ($urandom_range(0, 3))
                0: begin
                    hour_in = W'($urandom_range(0, 63));
                    min_in  = W'($urandom_range(0, 63));
                    sec_in  = W'($urandom_range(0, 63));
                end
                1: begin
                    hour_in = W'($urandom_range(0, HOUR_MAX));
                    min_in  = W'($urandom_range(0, MIN_MAX));
                    sec_in  = W'($urandom_range(0, SEC_MAX));
                end
                default: begin
                    hour_in = W'(HOUR_MAX);
                    min_in  = W'(MIN_MAX);
                    sec_in  = W'($urandom_range(45, SEC_MAX));
                end
            endcase
            alarm_hour = ($urandom_range(0, 1) == 1) ? W'(HOUR_MAX) : W'(0);
            alarm_min  = ($urandom_range(0, 1) == 1) ? W'(MIN_MAX) : W'(0);
            alarm_sec  = W'($urandom_range(0, 63));
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
